hazard_ctrl: RTL and testbench

// - Stall/bypass controller for the 5-stage pipeline datapath; drives its en_PC, en_D and clr inputs.
// - Keeps its own shadow E/M/W scoreboard of destination register (A3) and Tnew, plus a HI/LO multiply/divide busy counter.
// - Compares D-stage Tuse against E/M Tnew to decide stalls.
// - Produces D-stage bypass selects for the GRF read ports (V1/V2 feeding CMP/NPC).

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Stall/bypass controller for the 5-stage pipeline. Keeps a shadow E/M/W
// scoreboard of destination register and Tnew, plus a HI/LO busy counter for
// the multiply/divide unit, and decides D-stage stalls and bypass selects.
//
// Optional feature: define HAZARD_STALL_CNT_EN to add a 32-bit free-running
// count of stalled cycles (output stall_cnt).
//
// Ports
//   clk, reset          clock (rising edge), async active-high reset
//   rs_d, rt_d          D-stage source registers (0 = not read)
//   tuse_rs_d/tuse_rt_d cycles until operand is needed; 3 = not used
//   a3_d, tnew_d        D-stage destination and its Tnew on entering E
//   md_start_d          D instr starts mult/div; md_div_d selects div
//   md_use_d            D instr touches HI/LO
//   en_PC, en_D, clr    PC enable, D register enable, E flush
//   fwd_rs, fwd_rt      D bypass select: 0 GRF, 1 E, 2 M, 3 W
//   md_busy             multiply/divide unit busy
//   stall_cnt           (HAZARD_STALL_CNT_EN only) stalled-cycle count
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] a3_d,
    input  logic [1:0] tnew_d,
    input  logic       md_start_d,
    input  logic       md_div_d,
    input  logic       md_use_d,
    output logic       en_PC,
    output logic       en_D,
    output logic       clr,
    output logic [1:0] fwd_rs,
    output logic [1:0] fwd_rt,
    output logic       md_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    logic [4:0]       a3_e, a3_m, a3_w;
    logic [1:0]       tnew_e, tnew_m;
    logic             md_e;
    logic             md_div;
    logic [CNT_W-1:0] cnt;

    logic stall_rs, stall_rt, stall_md, stall;

    // A source only stalls if its producer will not be ready by the time the
    // operand is consumed; tuse=3 never compares below any Tnew.
    assign stall_rs = (rs_d != 5'd0) &&
                      (((rs_d == a3_e) && (tuse_rs_d < tnew_e)) ||
                       ((rs_d == a3_m) && (tuse_rs_d < tnew_m)));
    assign stall_rt = (rt_d != 5'd0) &&
                      (((rt_d == a3_e) && (tuse_rt_d < tnew_e)) ||
                       ((rt_d == a3_m) && (tuse_rt_d < tnew_m)));
    // md_e covers the issue cycle before the counter has been loaded.
    assign stall_md = md_use_d && (md_busy || md_e);
    assign stall    = stall_rs | stall_rt | stall_md;

    assign en_PC   = ~stall;
    assign en_D    = ~stall;
    assign clr     = stall;
    assign md_busy = (cnt != '0);

    function automatic logic [1:0] bypass_sel(
        input logic [4:0] r,
        input logic [4:0] ae, input logic [1:0] te,
        input logic [4:0] am, input logic [1:0] tm,
        input logic [4:0] aw
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (r != 5'd0) begin
            if ((r == ae) && (te == 2'd0))      sel = 2'd1;
            else if ((r == am) && (tm == 2'd0)) sel = 2'd2;
            else if (r == aw)                   sel = 2'd3;
        end
        return sel;
    endfunction

    assign fwd_rs = bypass_sel(rs_d, a3_e, tnew_e, a3_m, tnew_m, a3_w);
    assign fwd_rt = bypass_sel(rt_d, a3_e, tnew_e, a3_m, tnew_m, a3_w);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a3_e   <= 5'd0;
            tnew_e <= 2'd0;
            a3_m   <= 5'd0;
            tnew_m <= 2'd0;
            a3_w   <= 5'd0;
            md_e   <= 1'b0;
            md_div <= 1'b0;
            cnt    <= '0;
        end else begin
            if (stall) begin
                a3_e   <= 5'd0;
                tnew_e <= 2'd0;
            end else begin
                a3_e   <= a3_d;
                tnew_e <= tnew_d;
            end
            a3_m   <= a3_e;
            tnew_m <= (tnew_e == 2'd0) ? 2'd0 : tnew_e - 2'd1;
            a3_w   <= a3_m;
            md_e   <= md_start_d && !stall;
            md_div <= md_start_d && md_div_d && !stall;
            if (md_e)
                cnt <= md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= 32'd0;
        else if (stall)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed pipeline scenarios followed by random
// instruction streams. Expected outputs come from a model that tracks issued
// instructions by issue cycle and derives stage position and remaining
// latency arithmetically; a monitor pops and compares every cycle.
module tb_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, a3_d;
    logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
    logic       md_start_d, md_div_d, md_use_d;
    logic       en_PC, en_D, clr, md_busy;
    logic [1:0] fwd_rs, fwd_rt;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d),
        .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
        .a3_d(a3_d), .tnew_d(tnew_d),
        .md_start_d(md_start_d), .md_div_d(md_div_d), .md_use_d(md_use_d),
        .en_PC(en_PC), .en_D(en_D), .clr(clr),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int rs, rt, tuse_rs, tuse_rt, a3, tnew;
        bit md_start, md_div, md_use;
    } instr_t;

    typedef struct {
        int cyc;
        int a3;
        int tnew;
    } prod_t;

    typedef struct {
        bit en_pc, en_d, clr, md_busy;
        int fwd_rs, fwd_rt;
        int unsigned sc;
    } exp_t;

    prod_t       log_q[$];
    exp_t        exp_q[$];
    int          cyc = 0;
    int          md_cyc = -1000;
    int          md_n = 0;
    int unsigned sc_model = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Remaining Tnew of a producer, given it entered E one cycle after issue.
    function automatic int rem(prod_t p, int c);
        int r;
        r = p.tnew - (c - 1 - p.cyc);
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit hazard(int r, int tuse, int c);
        if (r == 0) return 1'b0;
        foreach (log_q[i])
            if ((log_q[i].cyc == c - 1 || log_q[i].cyc == c - 2) &&
                log_q[i].a3 == r && tuse < rem(log_q[i], c))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic int fwd_model(int r, int c);
        if (r == 0) return 0;
        foreach (log_q[i])
            if (log_q[i].cyc == c - 1 && log_q[i].a3 == r && rem(log_q[i], c) == 0) return 1;
        foreach (log_q[i])
            if (log_q[i].cyc == c - 2 && log_q[i].a3 == r && rem(log_q[i], c) == 0) return 2;
        foreach (log_q[i])
            if (log_q[i].cyc == c - 3 && log_q[i].a3 == r) return 3;
        return 0;
    endfunction

    function automatic instr_t mk(int rs, int rt, int trs, int trt, int a3, int tn,
                                  bit ms, bit md, bit mu);
        instr_t x;
        x.rs = rs; x.rt = rt; x.tuse_rs = trs; x.tuse_rt = trt;
        x.a3 = a3; x.tnew = tn; x.md_start = ms; x.md_div = md; x.md_use = mu;
        return x;
    endfunction

    // One clock cycle: drive D-stage inputs, predict outputs, advance model.
    task automatic run_cycle(input instr_t ins, input bit rst_now, output bit stalled);
        exp_t e;
        bit   st;
        int   c;
        @(posedge clk);
        #1;
        reset      = rst_now;
        rs_d       = 5'(ins.rs);
        rt_d       = 5'(ins.rt);
        tuse_rs_d  = 2'(ins.tuse_rs);
        tuse_rt_d  = 2'(ins.tuse_rt);
        a3_d       = 5'(ins.a3);
        tnew_d     = 2'(ins.tnew);
        md_start_d = ins.md_start;
        md_div_d   = ins.md_div;
        md_use_d   = ins.md_use;
        if (rst_now) begin
            log_q.delete();
            md_cyc   = -1000;
            sc_model = 0;
        end
        c  = cyc;
        st = hazard(ins.rs, ins.tuse_rs, c) || hazard(ins.rt, ins.tuse_rt, c) ||
             (ins.md_use && c >= md_cyc + 1 && c <= md_cyc + 1 + md_n);
        e.en_pc   = !st;
        e.en_d    = !st;
        e.clr     = st;
        e.md_busy = (c >= md_cyc + 2 && c <= md_cyc + 1 + md_n);
        e.fwd_rs  = fwd_model(ins.rs, c);
        e.fwd_rt  = fwd_model(ins.rt, c);
        e.sc      = sc_model;
        exp_q.push_back(e);
        if (!rst_now) begin
            if (st) sc_model++;
            else begin
                if (ins.a3 != 0) begin
                    prod_t p;
                    p.cyc = c; p.a3 = ins.a3; p.tnew = ins.tnew;
                    log_q.push_back(p);
                end
                if (ins.md_start) begin
                    md_cyc = c;
                    md_n   = ins.md_div ? DIV_N : MULT_N;
                end
            end
        end
        while (log_q.size() > 0 && log_q[0].cyc < c - 4) void'(log_q.pop_front());
        cyc++;
        stalled = st;
    endtask

    // Hold an instruction in D until the model says it moves on.
    task automatic issue(input instr_t ins);
        bit st;
        int n;
        n = 0;
        do begin
            run_cycle(ins, 1'b0, st);
            n++;
        end while (st && n < 40);
        if (st) begin
            checks++;
            errors++;
            $display("FAIL issue_bound: still stalled after %0d cycles, expected release", n);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("en_PC",   int'(en_PC),   int'(e.en_pc));
            chk("en_D",    int'(en_D),    int'(e.en_d));
            chk("clr",     int'(clr),     int'(e.clr));
            chk("fwd_rs",  int'(fwd_rs),  e.fwd_rs);
            chk("fwd_rt",  int'(fwd_rt),  e.fwd_rt);
            chk("md_busy", int'(md_busy), int'(e.md_busy));
`ifdef HAZARD_STALL_CNT_EN
            chk("stall_cnt", int'(stall_cnt), int'(e.sc));
`endif
        end
    end

    initial begin
        instr_t nop, ins;
        bit     st;
        reset = 1'b1;
        rs_d = 0; rt_d = 0; tuse_rs_d = 2'd3; tuse_rt_d = 2'd3;
        a3_d = 0; tnew_d = 0; md_start_d = 0; md_div_d = 0; md_use_d = 0;
        nop = mk(0, 0, 3, 3, 0, 0, 0, 0, 0);

        // Reset state, then a reset cycle with a hazard-looking input.
        run_cycle(nop, 1'b1, st);
        run_cycle(mk(5, 6, 0, 0, 7, 2, 0, 0, 1), 1'b1, st);

        // lw $9 then beq on $9: two stalls, then W bypass.
        issue(mk(0, 0, 3, 3, 9, 2, 0, 0, 0));
        issue(mk(9, 0, 0, 3, 0, 0, 0, 0, 0));
        repeat (3) issue(nop);

        // addu $8 then beq on $8: one stall, then M bypass.
        issue(mk(0, 0, 3, 3, 8, 1, 0, 0, 0));
        issue(mk(8, 0, 0, 3, 0, 0, 0, 0, 0));
        repeat (3) issue(nop);

        // addu $8 then addu reading $8 in E: no stall.
        issue(mk(0, 0, 3, 3, 8, 1, 0, 0, 0));
        issue(mk(8, 0, 1, 3, 10, 1, 0, 0, 0));
        issue(mk(0, 10, 3, 0, 0, 0, 0, 0, 0));
        repeat (3) issue(nop);

        // div then mflo: 11 stalled cycles.
        issue(mk(0, 0, 3, 3, 0, 0, 1, 1, 1));
        issue(mk(0, 0, 3, 3, 2, 1, 0, 0, 1));
        repeat (3) issue(nop);

        // Bubble with nonzero Tnew, then $0 reads: never a hazard.
        issue(mk(0, 0, 3, 3, 0, 2, 0, 0, 0));
        issue(mk(0, 0, 0, 0, 3, 1, 0, 0, 0));
        repeat (2) issue(nop);

        // Reset in the middle of a div, then mflo must not stall.
        issue(mk(0, 0, 3, 3, 0, 0, 1, 1, 1));
        repeat (5) issue(nop);
        run_cycle(mk(0, 0, 3, 3, 2, 1, 0, 0, 1), 1'b1, st);
        issue(mk(0, 0, 3, 3, 2, 1, 0, 0, 1));

        // mult then mflo: 1 + MULT_N stalls.
        issue(mk(0, 0, 3, 3, 0, 0, 1, 0, 1));
        issue(mk(0, 0, 3, 3, 4, 1, 0, 0, 1));
        repeat (3) issue(nop);

        // Random instruction stream with occasional resets.
        for (int k = 0; k < 600; k++) begin
            int sel;
            ins = mk(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
                     1'b0, 1'b0, 1'b0);
            sel = int'($urandom_range(0, 19));
            if (sel == 0 || sel == 1) begin
                ins.md_start = 1'b1;
                ins.md_div   = (sel == 1);
                ins.md_use   = 1'b1;
                ins.a3       = 0;
            end else if (sel == 2 || sel == 3) begin
                ins.md_use = 1'b1;
            end
            if ($urandom_range(0, 59) == 0)
                run_cycle(ins, 1'b1, st);
            issue(ins);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
